// File: rtl/impulse_frame_tx.sv
// impulse_frame_tx: emits framed bursts of WIDTH-bit signed ramp samples with a
// single marker sample at a programmable index, using a valid/ready handshake.
// Optional feature macro: IMPULSE_FRAME_TX_CONT_EN adds a 'cont' input. When it
// is high at the end of a frame's idle gap, the next frame starts immediately.
module impulse_frame_tx #(
   parameter int WIDTH     = 7,
   parameter int FRAME_LEN = 33,
   parameter int GAP_LEN   = 4,
   parameter int MARK_VAL  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       mark_pos,
   input  logic [WIDTH-1:0] base_val,
   input  logic             ready,
`ifdef IMPULSE_FRAME_TX_CONT_EN
   input  logic             cont,
`endif
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             sof,
   output logic             eof,
   output logic             busy,
   output logic             done,
   output logic [7:0]       frame_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [5:0]       LAST_IDX = 6'(FRAME_LEN - 1);
   localparam logic [3:0]       GAP_INIT = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;
   localparam logic [WIDTH-1:0] MARK_W   = WIDTH'(MARK_VAL);
   localparam bit               HAS_GAP  = (GAP_LEN > 0);

   // Sample at a given frame index: marker at the marker index, ramp elsewhere.
   // A marker index beyond the frame never matches, giving a pure ramp.
   function automatic logic [WIDTH-1:0] sample_at(input logic [5:0]       idx,
                                                  input logic [5:0]       mpos,
                                                  input logic [WIDTH-1:0] base);
      logic [WIDTH-1:0] res;
      if (idx == mpos) begin
         res = MARK_W;
      end else begin
         res = base + WIDTH'(idx);
      end
      return res;
   endfunction

   state_t           state_q;
   logic [5:0]       idx_q;
   logic [5:0]       mark_pos_q;
   logic [WIDTH-1:0] base_val_q;
   logic [3:0]       gap_cnt_q;
   logic [WIDTH-1:0] data_out_q;
   logic             valid_q;
   logic             sof_q;
   logic             eof_q;
   logic             busy_q;
   logic             done_q;
   logic [7:0]       frame_cnt_q;

   logic [5:0]       idx_d;
   logic [WIDTH-1:0] next_sample_d;
   logic [WIDTH-1:0] first_sample_d;
   logic [WIDTH-1:0] restart_sample_d;
   logic             cont_s;

`ifdef IMPULSE_FRAME_TX_CONT_EN
   assign cont_s = cont;
`else
   assign cont_s = 1'b0;
`endif

   // Next index and the candidate samples for advance, new start and restart.
   always_comb begin
      idx_d            = idx_q + 6'd1;
      next_sample_d    = sample_at(idx_d, mark_pos_q, base_val_q);
      first_sample_d   = sample_at(6'd0, mark_pos, base_val);
      restart_sample_d = sample_at(6'd0, mark_pos_q, base_val_q);
   end

   // Frame FSM with all outputs registered; reset aborts any frame silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 6'd0;
         mark_pos_q  <= 6'd0;
         base_val_q  <= '0;
         gap_cnt_q   <= 4'd0;
         data_out_q  <= '0;
         valid_q     <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mark_pos_q <= mark_pos;
                  base_val_q <= base_val;
                  idx_q      <= 6'd0;
                  data_out_q <= first_sample_d;
                  valid_q    <= 1'b1;
                  sof_q      <= 1'b1;
                  eof_q      <= (LAST_IDX == 6'd0);
                  busy_q     <= 1'b1;
                  state_q    <= ST_SEND;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SEND: begin
               // valid is always high here, so ready alone signals a transfer
               if (!ready) begin
                  state_q <= ST_SEND;
               end else if (idx_q != LAST_IDX) begin
                  idx_q      <= idx_d;
                  data_out_q <= next_sample_d;
                  sof_q      <= 1'b0;
                  eof_q      <= (idx_d == LAST_IDX);
               end else if (HAS_GAP) begin
                  data_out_q <= '0;
                  valid_q    <= 1'b0;
                  sof_q      <= 1'b0;
                  eof_q      <= 1'b0;
                  gap_cnt_q  <= GAP_INIT;
                  state_q    <= ST_GAP;
               end else if (cont_s) begin
                  idx_q       <= 6'd0;
                  data_out_q  <= restart_sample_d;
                  sof_q       <= 1'b1;
                  eof_q       <= (LAST_IDX == 6'd0);
                  done_q      <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 8'd1;
               end else begin
                  data_out_q  <= '0;
                  valid_q     <= 1'b0;
                  sof_q       <= 1'b0;
                  eof_q       <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 8'd1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q != 4'd0) begin
                  gap_cnt_q <= gap_cnt_q - 4'd1;
               end else if (cont_s) begin
                  idx_q       <= 6'd0;
                  data_out_q  <= restart_sample_d;
                  valid_q     <= 1'b1;
                  sof_q       <= 1'b1;
                  eof_q       <= (LAST_IDX == 6'd0);
                  done_q      <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 8'd1;
                  state_q     <= ST_SEND;
               end else begin
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 8'd1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               data_out_q <= '0;
               valid_q    <= 1'b0;
               sof_q      <= 1'b0;
               eof_q      <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = data_out_q;
   assign valid     = valid_q;
   assign sof       = sof_q;
   assign eof       = eof_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_impulse_frame_tx.sv
// Directed bench for impulse_frame_tx (default parameters).
// Flags are compared as {valid, sof, eof, busy, done}.
module tb_impulse_frame_tx;

   localparam int W = 7;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [5:0]   mark_pos;
   logic [W-1:0] base_val;
   logic         ready;
`ifdef IMPULSE_FRAME_TX_CONT_EN
   logic         cont;
`endif
   logic [W-1:0] data_out;
   logic         valid;
   logic         sof;
   logic         eof;
   logic         busy;
   logic         done;
   logic [7:0]   frame_cnt;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   impulse_frame_tx dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mark_pos  (mark_pos),
      .base_val  (base_val),
      .ready     (ready),
`ifdef IMPULSE_FRAME_TX_CONT_EN
      .cont      (cont),
`endif
      .data_out  (data_out),
      .valid     (valid),
      .sof       (sof),
      .eof       (eof),
      .busy      (busy),
      .done      (done),
      .frame_cnt (frame_cnt)
   );

   // Expected sample: 3 at the marker index, else base+idx wrapped to 7 bits.
   function automatic logic [W-1:0] exp_s(input int base, input int mark, input int idx);
      int v;
      if (idx == mark) return 7'd3;
      v = base + idx;
      return v[6:0];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; ready = 1'b0; mark_pos = 6'd0; base_val = 7'd0;
`ifdef IMPULSE_FRAME_TX_CONT_EN
      cont = 1'b0;
`endif
      tick; tick;
      chk_cnt++;
      if ({valid, sof, eof, busy, done} !== 5'b00000) $display("FAIL reset_flags got=%b exp=00000", {valid, sof, eof, busy, done});
      else pass_cnt++;
      chk_cnt++;
      if (data_out !== 7'd0) $display("FAIL reset_data got=%0d exp=0", data_out);
      else pass_cnt++;
      chk_cnt++;
      if (frame_cnt !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", frame_cnt);
      else pass_cnt++;
      rst = 1'b0;
      tick;
      chk_cnt++;
      if ({valid, busy, done} !== 3'b000) $display("FAIL idle_after_reset got=%b exp=000", {valid, busy, done});
      else pass_cnt++;
   endtask

   task automatic test_basic_frame;
      mark_pos = 6'd8; base_val = -7'sd5; ready = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 33; i++) begin
         chk_cnt++;
         if ({valid, sof, eof, busy, done} !== {1'b1, (i == 0), (i == 32), 1'b1, 1'b0})
            $display("FAIL basic_flags idx=%0d got=%b", i, {valid, sof, eof, busy, done});
         else pass_cnt++;
         chk_cnt++;
         if (data_out !== exp_s(-5, 8, i))
            $display("FAIL basic_data idx=%0d got=%0d exp=%0d", i, $signed(data_out), $signed(exp_s(-5, 8, i)));
         else pass_cnt++;
         tick;
      end
      for (int g = 0; g < 4; g++) begin
         chk_cnt++;
         if ({valid, sof, eof, busy, done} !== 5'b00010) $display("FAIL basic_gap g=%0d got=%b exp=00010", g, {valid, sof, eof, busy, done});
         else pass_cnt++;
         tick;
      end
      chk_cnt++;
      if ({valid, busy, done} !== 3'b001) $display("FAIL basic_done got=%b exp=001", {valid, busy, done});
      else pass_cnt++;
      chk_cnt++;
      if (frame_cnt !== 8'd1) $display("FAIL basic_cnt got=%0d exp=1", frame_cnt);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if ({valid, busy, done} !== 3'b000) $display("FAIL basic_done_pulse got=%b exp=000", {valid, busy, done});
      else pass_cnt++;
   endtask

   task automatic test_wrap;
      int n;
      mark_pos = 6'd63; base_val = 7'd60; ready = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 33; i++) begin
         chk_cnt++;
         if (data_out !== exp_s(60, 63, i) || valid !== 1'b1)
            $display("FAIL wrap_data idx=%0d got=%0d/v%b exp=%0d", i, $signed(data_out), valid, $signed(exp_s(60, 63, i)));
         else pass_cnt++;
         tick;
      end
      n = 0;
      while (done !== 1'b1 && n < 20) begin tick; n++; end
      chk_cnt++;
      if (n !== 4) $display("FAIL wrap_gap_len got=%0d exp=4", n);
      else pass_cnt++;
      chk_cnt++;
      if (frame_cnt !== 8'd2) $display("FAIL wrap_cnt got=%0d exp=2", frame_cnt);
      else pass_cnt++;
   endtask

   task automatic test_backpressure;
      int idx, st5, st32, vcyc, cyc, n;
      mark_pos = 6'd2; base_val = 7'd10; ready = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      idx = 0; st5 = 0; st32 = 0; vcyc = 0; cyc = 0;
      while (idx < 33 && cyc < 100) begin
         chk_cnt++;
         if ({valid, sof, eof} !== {1'b1, (idx == 0), (idx == 32)})
            $display("FAIL bp_flags idx=%0d got=%b", idx, {valid, sof, eof});
         else pass_cnt++;
         chk_cnt++;
         if (data_out !== exp_s(10, 2, idx))
            $display("FAIL bp_data idx=%0d got=%0d exp=%0d", idx, $signed(data_out), $signed(exp_s(10, 2, idx)));
         else pass_cnt++;
         if (valid === 1'b1) vcyc++;
         if (idx == 5 && st5 < 3) begin ready = 1'b0; st5++; end
         else if (idx == 32 && st32 < 3) begin ready = 1'b0; st32++; end
         else ready = 1'b1;
         tick;
         if (ready) idx++;
         cyc++;
      end
      ready = 1'b1;
      chk_cnt++;
      if (vcyc !== 39 || idx !== 33) $display("FAIL bp_valid_cycles got=%0d/%0d exp=39/33", vcyc, idx);
      else pass_cnt++;
      chk_cnt++;
      if (valid !== 1'b0) $display("FAIL bp_end_valid got=%b exp=0", valid);
      else pass_cnt++;
      n = 0;
      while (done !== 1'b1 && n < 20) begin tick; n++; end
      chk_cnt++;
      if (done !== 1'b1 || frame_cnt !== 8'd3) $display("FAIL bp_done got=%b/%0d exp=1/3", done, frame_cnt);
      else pass_cnt++;
   endtask

   task automatic test_ignore_start;
      mark_pos = 6'd40; base_val = 7'd0; ready = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 33; i++) begin
         chk_cnt++;
         if (data_out !== exp_s(0, 40, i) || frame_cnt !== 8'd3 || sof !== (i == 0))
            $display("FAIL ign_send idx=%0d got=%0d/%0d/%b", i, $signed(data_out), frame_cnt, sof);
         else pass_cnt++;
         start = (i == 10);
         tick;
      end
      start = 1'b0;
      for (int g = 0; g < 4; g++) begin
         chk_cnt++;
         if ({valid, sof, eof, busy, done} !== 5'b00010 || frame_cnt !== 8'd3)
            $display("FAIL ign_gap g=%0d got=%b/%0d", g, {valid, sof, eof, busy, done}, frame_cnt);
         else pass_cnt++;
         start = (g == 1);
         tick;
      end
      start = 1'b0;
      chk_cnt++;
      if (done !== 1'b1 || frame_cnt !== 8'd4) $display("FAIL ign_done got=%b/%0d exp=1/4", done, frame_cnt);
      else pass_cnt++;
      mark_pos = 6'd0; base_val = 7'd0; start = 1'b1;
      tick;
      start = 1'b0;
      chk_cnt++;
      if ({valid, sof, eof, busy, done} !== 5'b11010) $display("FAIL done_cycle_start got=%b exp=11010", {valid, sof, eof, busy, done});
      else pass_cnt++;
      chk_cnt++;
      if (data_out !== 7'd3) $display("FAIL done_cycle_mark0 got=%0d exp=3", data_out);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int n;
      for (int i = 0; i < 20; i++) tick;
      chk_cnt++;
      if (data_out !== 7'd20 || valid !== 1'b1) $display("FAIL mid_idx20 got=%0d/v%b exp=20", data_out, valid);
      else pass_cnt++;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk_cnt++;
      if ({valid, sof, eof, busy, done} !== 5'b00000 || frame_cnt !== 8'd0 || data_out !== 7'd0)
         $display("FAIL mid_abort got=%b/%0d/%0d", {valid, sof, eof, busy, done}, frame_cnt, data_out);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if ({valid, busy, done} !== 3'b000 || frame_cnt !== 8'd0) $display("FAIL mid_no_done got=%b/%0d", {valid, busy, done}, frame_cnt);
      else pass_cnt++;
      mark_pos = 6'd8; base_val = -7'sd5; start = 1'b1;
      tick;
      start = 1'b0;
      chk_cnt++;
      if ({valid, sof} !== 2'b11 || data_out !== exp_s(-5, 8, 0)) $display("FAIL mid_restart got=%b/%0d exp=11/-5", {valid, sof}, $signed(data_out));
      else pass_cnt++;
      tick;
      chk_cnt++;
      if (sof !== 1'b0 || data_out !== exp_s(-5, 8, 1)) $display("FAIL mid_restart_idx1 got=%b/%0d exp=0/-4", sof, $signed(data_out));
      else pass_cnt++;
      n = 0;
      while (done !== 1'b1 && n < 60) begin tick; n++; end
      chk_cnt++;
      if (done !== 1'b1 || frame_cnt !== 8'd1) $display("FAIL mid_final got=%b/%0d exp=1/1", done, frame_cnt);
      else pass_cnt++;
      tick;
   endtask

`ifdef IMPULSE_FRAME_TX_CONT_EN
   task automatic test_cont;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      cont = 1'b1; mark_pos = 6'd5; base_val = 7'd0; ready = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 33; i++) begin
            chk_cnt++;
            if ({valid, sof, eof, busy, done} !== {1'b1, (i == 0), (i == 32), 1'b1, (f > 0 && i == 0)} ||
                data_out !== exp_s(0, 5, i))
               $display("FAIL cont_send f=%0d idx=%0d got=%b/%0d", f, i, {valid, sof, eof, busy, done}, data_out);
            else pass_cnt++;
            if (i == 0) begin
               chk_cnt++;
               if (frame_cnt !== 8'(f)) $display("FAIL cont_cnt f=%0d got=%0d exp=%0d", f, frame_cnt, f);
               else pass_cnt++;
            end
            tick;
         end
         if (f == 2) cont = 1'b0;
         for (int g = 0; g < 4; g++) begin
            chk_cnt++;
            if ({valid, sof, eof, busy, done} !== 5'b00010) $display("FAIL cont_gap f=%0d g=%0d got=%b", f, g, {valid, sof, eof, busy, done});
            else pass_cnt++;
            tick;
         end
      end
      chk_cnt++;
      if ({valid, busy, done} !== 3'b001 || frame_cnt !== 8'd3) $display("FAIL cont_end got=%b/%0d exp=001/3", {valid, busy, done}, frame_cnt);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if ({valid, busy, done} !== 3'b000) $display("FAIL cont_idle got=%b exp=000", {valid, busy, done});
      else pass_cnt++;
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_frame();
      test_wrap();
      test_backpressure();
      test_ignore_start();
      test_reset_mid();
`ifdef IMPULSE_FRAME_TX_CONT_EN
      test_cont();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
